ternary_neuron_serial: RTL and testbench
========================================

Name: ternary_neuron_serial

Overview:
- Sequential, parametrised successor to the fixed 5-input, 3-bit combinational threshold neurons produced for the TNN classifiers.
- Streams N_IN unsigned operands, one per beat, each paired with a ternary weight (+1/0/-1). Accumulates them into a saturating signed sum and emits one decision bit: sum > threshold.
- Adds an optional LSB-truncation approximation mode, a result hold under backpressure, and a synchronous abort.
- Sits between the feature-quantisation stage and the next TNN layer's input buffer.

Parameters:
- N_IN, 5, operands per evaluation (>=1).
- IN_W, 3, operand width, unsigned.
- ACC_W, 7, signed accumulator/threshold width; must cover the range ±N_IN*(2^IN_W-1) for exact results.
- TRUNC_LSB, 0, low operand bits forced to 0 before accumulation (0 = exact; 0..IN_W-1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clr  input  1  synchronous abort of the current evaluation.
- thresh  input  ACC_W  signed threshold, sampled on the first accepted beat.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  IN_W  unsigned operand.
- in_weight  input  2  weight code: 01 = +1, 11 = -1, 00 = 0, 10 = reserved (treated as 0).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_bit  output  1  decision: 1 when sum > thresh_q (strict).
- out_sum  output  ACC_W  signed final sum, for debug and scoring.
- bad_weight  output  1  sticky flag, set by any accepted beat carrying code 10.

Behaviour:
- Reset (rst_n=0, asynchronous): state=ACCUM, cnt=0, acc=0, thresh_q=0, out_valid=0, out_bit=0, out_sum=0, bad_weight=0.
- States: ACCUM and HOLD.
  - in_ready = (state==ACCUM).
  - out_valid = (state==HOLD).
- ACCUM:
  - A beat is accepted when in_valid & in_ready.
  - On accept: op = in_data with the low TRUNC_LSB bits zeroed, zero-extended to ACC_W.
  - acc_next = sat(acc + w*op).
  - cnt increments.
  - On the first beat (cnt==0), thresh_q <= thresh.
- Saturation: the result is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on every add. Once clamped, later adds continue from the clamped value.
- Transition to HOLD: the beat with cnt==N_IN-1 is accepted at edge k. After edge k:
  - out_sum = final acc.
  - out_bit = (final acc > thresh_q), signed compare.
  - out_valid = 1.
  - Latency is one cycle from the last beat to out_valid.
  - acc and cnt clear at the same edge.
- HOLD:
  - out_valid, out_bit and out_sum stay stable until out_ready=1.
  - in_ready=0, so no beat is accepted.
  - A handshake at edge j returns the block to ACCUM; in_ready=1 in the cycle after edge j.
  - Steady-state throughput is one result per N_IN+1 cycles with out_ready tied high.
- in_valid=0 cycles inside ACCUM: acc and cnt hold, with no timeout.
- clr=1 at an edge: state=ACCUM, acc=0, cnt=0, out_valid=0.
  - The pending result is discarded.
  - bad_weight is preserved; only rst_n clears it.
  - clr has priority over a simultaneous input or output handshake in the same cycle.
- Reset mid-evaluation: the partial sum is lost, and no out_valid is produced for the aborted evaluation.
- N_IN=1: each accepted beat produces a result directly.
- Width rules: thresh is two's-complement. out_sum is the saturated accumulator value, not wrapped.

Test Plan:
- Default parameters, thresh=0, weights (+1,+1,-1,-1,-1), data (7,7,3,3,3), out_ready=1.
  - Required: out_sum=5, out_bit=1, out_valid high exactly one cycle after the 5th accepted beat.
- Same weights, data (3,3,2,2,2), thresh=0.
  - Required: out_sum=0, out_bit=0 (strict compare).
  - Repeat with thresh=-1: out_bit=1.
- ACC_W=4, all weights +1, data all 7.
  - Required: acc saturates at 7 from beat 2; out_sum=7, out_bit=1 for thresh=6.
  - All weights -1: out_sum=-8.
- TRUNC_LSB=1, weights (+1,+1,-1,-1,-1), data (7,7,3,3,3).
  - Required: effective operands (6,6,2,2,2), out_sum=6, out_bit=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises, with in_valid=1 throughout.
  - Required: out_bit and out_sum stable, in_ready=0, no beat consumed.
  - After the handshake, the next evaluation starts fresh from acc=0.
- Abort and reset:
  - Pulse clr after 3 beats: out_valid never asserts for that evaluation; the next 5 beats give the correct fresh sum.
  - Drop rst_n asynchronously mid-clock after 2 beats: all outputs go to 0 immediately.
  - Send a weight code 10: bad_weight=1 and stays set through clr; the beat contributes 0.

Source files
------------

// File: rtl/ternary_neuron_serial_if.sv
// Operand-stream and result handshake bundle for the serial ternary neuron.
interface ternary_neuron_serial_if #(
    parameter int IN_W  = 3,
    parameter int ACC_W = 7
);
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         in_data;
    logic [1:0]              in_weight;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_bit;
    logic signed [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_bit, out_sum
    );

    modport slave (
        input  in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_bit, out_sum
    );
endinterface

// File: rtl/ternary_neuron_serial.sv
// Serial ternary-weight threshold neuron: saturating signed accumulate of
// N_IN weighted beats, then a held strict-greater-than decision.
module ternary_neuron_serial #(
    parameter int N_IN      = 5,
    parameter int IN_W      = 3,
    parameter int ACC_W     = 7,
    parameter int TRUNC_LSB = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic signed [ACC_W-1:0] thresh,
    ternary_neuron_serial_if.slave  bus,
    output logic                    bad_weight
);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int SW    = ACC_W + 2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);
    localparam logic [IN_W-1:0]  KEEP = {IN_W{1'b1}} << TRUNC_LSB;

    localparam logic signed [SW-1:0] HI = SW'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [SW-1:0] LO = ~HI;

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] thresh_q;
    logic signed [ACC_W-1:0] thr_eff;
    logic signed [ACC_W-1:0] acc_nx;
    logic signed [ACC_W-1:0] sum_q;
    logic                    bit_q;
    logic signed [SW-1:0]    op;
    logic signed [SW-1:0]    term;
    logic signed [SW-1:0]    sum;
    logic                    w_pos;
    logic                    w_neg;
    logic                    accept;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_bit   = bit_q;
    assign bus.out_sum   = sum_q;

    assign accept = bus.in_valid && (state == ACCUM);
    assign w_pos  = (bus.in_weight == 2'b01);
    assign w_neg  = (bus.in_weight == 2'b11);

    // With N_IN=1 the first beat is also the last, so compare
    // against the live threshold rather than the not-yet-loaded copy.
    assign thr_eff = (cnt == '0) ? thresh : thresh_q;

    always_comb begin
        op   = SW'(bus.in_data & KEEP);
        term = '0;
        unique case (1'b1)
            w_pos:   term = op;
            w_neg:   term = -op;
            default: term = '0;
        endcase
        sum = SW'(acc) + term;
        if (sum > HI) begin
            acc_nx = HI[ACC_W-1:0];
        end else if (sum < LO) begin
            acc_nx = LO[ACC_W-1:0];
        end else begin
            acc_nx = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            cnt        <= '0;
            acc        <= '0;
            thresh_q   <= '0;
            sum_q      <= '0;
            bit_q      <= 1'b0;
            bad_weight <= 1'b0;
        end else if (clr) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
        end else if (accept) begin
            if (bus.in_weight == 2'b10) begin
                bad_weight <= 1'b1;
            end
            if (cnt == '0) begin
                thresh_q <= thresh;
            end
            if (cnt == LAST) begin
                sum_q <= acc_nx;
                bit_q <= (acc_nx > thr_eff);
                state <= HOLD;
                acc   <= '0;
                cnt   <= '0;
            end else begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state <= ACCUM;
        end
    end
endmodule

// File: tb/tb_ternary_neuron_serial.sv
// Lockstep bench for three neuron configurations (exact, narrow accumulator,
// truncated LSB) driven by shared stimulus and checked against an arithmetic model.
`timescale 1ns/1ps
module tb_ternary_neuron_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              out_ready;
    logic [2:0]        in_data;
    logic [1:0]        in_weight;
    logic signed [6:0] thresh;
    logic signed [3:0] thresh4;

    int vectors = 0;
    int miscompares = 0;

    ternary_neuron_serial_if #(.IN_W(3), .ACC_W(7)) b0 ();
    ternary_neuron_serial_if #(.IN_W(3), .ACC_W(4)) b1 ();
    ternary_neuron_serial_if #(.IN_W(3), .ACC_W(7)) b2 ();

    logic [2:0] bw;

    ternary_neuron_serial #(.N_IN(5), .IN_W(3), .ACC_W(7), .TRUNC_LSB(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .thresh(thresh),
        .bus(b0), .bad_weight(bw[0])
    );
    ternary_neuron_serial #(.N_IN(5), .IN_W(3), .ACC_W(4), .TRUNC_LSB(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .thresh(thresh4),
        .bus(b1), .bad_weight(bw[1])
    );
    ternary_neuron_serial #(.N_IN(5), .IN_W(3), .ACC_W(7), .TRUNC_LSB(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .thresh(thresh),
        .bus(b2), .bad_weight(bw[2])
    );

    assign b0.in_valid = in_valid;
    assign b0.in_data = in_data;
    assign b0.in_weight = in_weight;
    assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid;
    assign b1.in_data = in_data;
    assign b1.in_weight = in_weight;
    assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid;
    assign b2.in_data = in_data;
    assign b2.in_weight = in_weight;
    assign b2.out_ready = out_ready;

    logic [2:0] ov;
    logic [2:0] ir;
    logic [2:0] ob;
    int         os [3];

    assign ov = {b2.out_valid, b1.out_valid, b0.out_valid};
    assign ir = {b2.in_ready, b1.in_ready, b0.in_ready};
    assign ob = {b2.out_bit, b1.out_bit, b0.out_bit};
    assign os[0] = int'(b0.out_sum);
    assign os[1] = int'(b1.out_sum);
    assign os[2] = int'(b2.out_sum);

    // Reference: weighted sum of truncated operands, clamped after every add.
    function automatic int ref_sum(input int d[5], input int w[5],
                                   input int accw, input int tr);
        int acc;
        int hi;
        int lo;
        acc = 0;
        hi = (1 << (accw - 1)) - 1;
        lo = -hi - 1;
        for (int i = 0; i < 5; i++) begin
            int op;
            int s;
            op = (d[i] >> tr) << tr;
            s = (w[i] == 1) ? 1 : ((w[i] == 3) ? -1 : 0);
            acc = acc + s * op;
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        return acc;
    endfunction

    task automatic run_eval(input int d[5], input int w[5], input int th,
                            input int th4, input int gap_max, input int hold,
                            input string tag);
        int es [3];
        int eb [3];
        es[0] = ref_sum(d, w, 7, 0);
        es[1] = ref_sum(d, w, 4, 0);
        es[2] = ref_sum(d, w, 7, 1);
        for (int k = 0; k < 3; k++) begin
            eb[k] = (es[k] > ((k == 1) ? th4 : th)) ? 1 : 0;
        end
        thresh = 7'(th);
        thresh4 = 4'(th4);
        out_ready = (hold == 0);
        for (int i = 0; i < 5; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data = 3'(d[i]);
            in_weight = 2'(w[i]);
            if (i == 4) begin
                vectors++;
                if (ov !== 3'b000) begin
                    miscompares++;
                    $display("FAIL %s early_valid got %b want 000", tag, ov);
                end
            end
            @(posedge clk); #1;
            if (i == 0) begin
                thresh = 7'($urandom);
                thresh4 = 4'($urandom);
            end
        end
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data = 3'd7;
            in_weight = 2'b01;
        end else begin
            in_valid = 1'b0;
        end
        for (int c = 0; c <= hold; c++) begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (ov[k] !== 1'b1 || ir[k] !== 1'b0 ||
                    ob[k] !== 1'(eb[k]) || os[k] !== es[k]) begin
                    miscompares++;
                    $display("FAIL %s result dut%0d cyc%0d got v=%b r=%b bit=%b sum=%0d want v=1 r=0 bit=%0d sum=%0d",
                             tag, k, c, ov[k], ir[k], ob[k], os[k], eb[k], es[k]);
                end
            end
            if (c < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (ov !== 3'b000 || ir !== 3'b111) begin
            miscompares++;
            $display("FAIL %s release got v=%b r=%b want v=000 r=111", tag, ov, ir);
        end
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = 3'($urandom_range(1, 7));
            in_weight = 2'b01;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || ob[k] !== 1'b0 ||
                os[k] !== 0 || bw[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset dut%0d got v=%b r=%b bit=%b sum=%0d bw=%b want 0 1 0 0 0",
                         k, ov[k], ir[k], ob[k], os[k], bw[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int d[5];
        int w[5];
        d = '{7, 7, 3, 3, 3};
        w = '{1, 1, 3, 3, 3};
        run_eval(d, w, 0, 0, 0, 0, "mixed_a");
        d = '{3, 3, 2, 2, 2};
        run_eval(d, w, 0, 0, 0, 0, "tie_zero");
        run_eval(d, w, -1, -1, 0, 0, "tie_neg1");
        d = '{7, 7, 7, 7, 7};
        w = '{1, 1, 1, 1, 1};
        run_eval(d, w, 6, 6, 0, 0, "sat_pos");
        w = '{3, 3, 3, 3, 3};
        run_eval(d, w, 6, 6, 0, 0, "sat_neg");
    endtask

    task automatic test_back_to_back();
        int d[5];
        int w[5];
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 5; i++) begin
                d[i] = int'($urandom_range(0, 7));
                w[i] = (i % 2 == 0) ? 1 : 3;
            end
            run_eval(d, w, n - 1, n - 1, 0, 0, "b2b");
        end
    endtask

    task automatic test_backpressure();
        int d[5];
        int w[5];
        d = '{5, 6, 1, 2, 4};
        w = '{1, 1, 3, 0, 1};
        run_eval(d, w, 3, 3, 0, 3, "bp_hold");
        d = '{1, 2, 3, 4, 5};
        w = '{3, 1, 3, 1, 3};
        run_eval(d, w, -2, -2, 0, 0, "bp_fresh");
    endtask

    task automatic test_clr();
        int d[5];
        int w[5];
        send_beats(3);
        in_valid = 1'b1;
        in_data = 3'd7;
        in_weight = 2'b01;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin
            vectors++;
            if (ov !== 3'b000 || ir !== 3'b111) begin
                miscompares++;
                $display("FAIL clr_abort got v=%b r=%b want v=000 r=111", ov, ir);
            end
            @(posedge clk); #1;
        end
        d = '{2, 7, 4, 1, 6};
        w = '{1, 3, 1, 1, 3};
        run_eval(d, w, 0, 0, 0, 0, "after_clr");
        out_ready = 1'b0;
        send_beats(5);
        vectors++;
        if (ov !== 3'b111) begin
            miscompares++;
            $display("FAIL clr_hold_pre got v=%b want 111", ov);
        end
        clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        vectors++;
        if (ov !== 3'b000 || ir !== 3'b111) begin
            miscompares++;
            $display("FAIL clr_hold got v=%b r=%b want v=000 r=111", ov, ir);
        end
    endtask

    task automatic test_bad_weight();
        int d[5];
        int w[5];
        vectors++;
        if (bw !== 3'b000) begin
            miscompares++;
            $display("FAIL bad_weight_init got %b want 000", bw);
        end
        d = '{4, 7, 3, 5, 6};
        w = '{1, 2, 1, 3, 1};
        run_eval(d, w, 5, 5, 0, 0, "bad_code");
        vectors++;
        if (bw !== 3'b111) begin
            miscompares++;
            $display("FAIL bad_weight_set got %b want 111", bw);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        vectors++;
        if (bw !== 3'b111) begin
            miscompares++;
            $display("FAIL bad_weight_clr got %b want 111", bw);
        end
    endtask

    task automatic test_reset_mid();
        int d[5];
        int w[5];
        send_beats(2);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ov[k] !== 1'b0 || ob[k] !== 1'b0 || os[k] !== 0 ||
                bw[k] !== 1'b0 || ir[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL async_reset dut%0d got v=%b bit=%b sum=%0d bw=%b r=%b want 0 0 0 0 1",
                         k, ov[k], ob[k], os[k], bw[k], ir[k]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        d = '{6, 1, 7, 2, 3};
        w = '{1, 1, 3, 1, 1};
        run_eval(d, w, 4, 4, 0, 0, "after_rst");
    endtask

    task automatic test_random();
        int d[5];
        int w[5];
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 5; i++) begin
                d[i] = int'($urandom_range(0, 7));
                w[i] = int'($urandom_range(0, 3));
            end
            run_eval(d, w, int'($urandom_range(0, 40)) - 20,
                     int'($urandom_range(0, 15)) - 8,
                     2, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_data = '0;
        in_weight = '0;
        thresh = '0;
        thresh4 = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_clr();
        test_bad_weight();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
